// File: rtl/gate_sweep_controller.sv
// Sweeps all four {a,b} vectors through the z = a & ~b gate datapath,
// samples z after a programmable settle time and tallies mismatches.
module gate_sweep_controller #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       z,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx
);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    FINISH
  } state_t;

  localparam logic [7:0] SettleLoad = 8'(SETTLE);

  state_t     state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= 8'd0;
      idx_q    <= 2'd0;
      err_q    <= 3'd0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
    end
  end

  // Expected z is high only for vector 2 (a=1, b=0).
  assign mismatch = (z != (idx_q[1] & ~idx_q[0]));

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    err_d    = err_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = 2'd0;
          err_d   = 3'd0;
          pass_d  = 1'b0;
        end
      end
      APPLY: begin
        settle_d = SettleLoad;
        state_d  = (SettleLoad == 8'd0) ? CHECK : WAIT;
      end
      WAIT: begin
        settle_d = settle_q - 8'd1;
        if (settle_q <= 8'd1) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        err_d = err_q + {2'b00, mismatch};
        if (idx_q == 2'd3) begin
          state_d = FINISH;
          pass_d  = (err_d == 3'd0);
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = APPLY;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // a/b come straight from the vector index register, so they are glitch-free.
  assign a         = idx_q[1];
  assign b         = idx_q[0];
  assign vec_idx   = idx_q;
  assign err_count = err_q;
  assign pass      = pass_q;
  assign busy      = (state_q == APPLY) || (state_q == WAIT) || (state_q == CHECK);
  assign done      = (state_q == FINISH);

endmodule

// File: doc/gate_sweep_controller.md
# gate_sweep_controller

Self-checking sequencer for the single-bit `z = a & ~b` gate datapath (one NOT gate feeding one AND gate). On a start request it drives all four `{a,b}` input combinations into the datapath. After each combination it waits a programmable settle time, samples `z` and compares it against the expected value. It then reports a pass/fail flag and an error count. It sits beside the gate datapath in the lab bench and replaces hand-written stimulus/display sequences.

## Interface
- `SETTLE`, default 2: cycles to wait between driving a vector and sampling `z`. Legal range is 0..255.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `z`  in  1  datapath output under test.
- `a`  out  1  datapath input a, registered.
- `b`  out  1  datapath input b, registered.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  1 if the last sweep had zero mismatches; valid from `done` until the next start.
- `err_count`  out  3  mismatches in the last or current sweep, range 0..4.
- `vec_idx`  out  2  index of the vector currently applied.

## Operation
- States: IDLE, APPLY, WAIT, CHECK, FINISH.
- Vector mapping: `a = vec_idx[1]`, `b = vec_idx[0]`. Order is idx 0,1,2,3. Expected `z` is 1 only at idx 2.
- **IDLE**
  - If `start`=1: go to APPLY. On the same edge set `vec_idx`=0, `a`=0, `b`=0, `err_count`=0, `pass`=0, `busy`=1.
  - Otherwise stay in IDLE. `a`, `b`, `vec_idx`, `err_count` and `pass` hold their values.
- **APPLY** (1 cycle)
  - Load the settle counter with `SETTLE`.
  - Go to WAIT, or go directly to CHECK if `SETTLE`=0.
- **WAIT**
  - Decrement the settle counter each cycle.
  - Go to CHECK in the cycle where the counter reaches 0, giving exactly `SETTLE` cycles in WAIT.
- **CHECK** (1 cycle)
  - Compare `z` against `a & ~b`. On mismatch, increment `err_count` (max 4, so no overflow in 3 bits).
  - If `vec_idx`=3: go to FINISH.
  - Otherwise: increment `vec_idx`, drive the new `{a,b}` on the same edge, and go to APPLY.
- **FINISH** (1 cycle)
  - `busy`=0, `done`=1.
  - `pass` is set to (`err_count`==0 including the final CHECK result). `pass` is registered on the CHECK→FINISH edge.
  - Return to IDLE.
- `start` is ignored in APPLY, WAIT, CHECK and FINISH. There is no queuing.
- After a sweep, `a`/`b` hold the last vector (1,1) until the next start.
- **Reset** (any state, mid-sweep included): on the next edge go to IDLE. All outputs go to 0, the settle counter goes to 0, and no `done` pulse is generated.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `vec_idx`=0, state IDLE.
- Let edge E0 be the edge that samples `start`=1 in IDLE.
  - `busy` is high from E0 for 4×(2+`SETTLE`) cycles.
  - `done` is high for the single following cycle.
  - With `SETTLE`=2: `busy` is high for 16 cycles and `done` is asserted in cycle 17 after E0.
  - With `SETTLE`=0: `busy` is high for 8 cycles and `done` is in cycle 9.
- Per vector: `a`/`b` are stable for 2+`SETTLE` cycles before the next change. `z` is sampled in the last of those cycles.
- `err_count` updates on the edge leaving CHECK and is visible in the following cycle.
- `start` sampled high in FINISH is ignored. `start` high in the next (IDLE) cycle begins a new sweep. If `start` is held high continuously, back-to-back sweeps are separated by one IDLE cycle.
- Latency from `start` to the first vector driven on `a`/`b`: 1 edge.

## Test plan
- **Reset check:** assert `reset` for 2 cycles → all outputs 0. Hold `start`=0 for 10 cycles → `busy` and `done` stay 0.
- **Good datapath** (combinational `z = a & ~b`, `SETTLE`=2): one-cycle `start` pulse → `busy`=1 for 16 cycles, `vec_idx` steps 0,1,2,3 every 4 cycles, `done` pulses in cycle 17, `pass`=1, `err_count`=0.
- **Faulty datapaths:**
  - `z` stuck at 0 → `err_count`=1, `pass`=0.
  - `z = a & b` (missing inverter) → mismatches at idx 2 and 3, `err_count`=2, `pass`=0.
  - `z = ~(a & ~b)` → `err_count`=4.
- **Start handling:** pulse `start` again at cycle 5 of a sweep → ignored, still one `done` total. Then hold `start` high → next sweep begins 1 cycle after `done` and `err_count`/`pass` clear at that start.
- **Reset mid-sweep:** assert `reset` at cycle 7 of a sweep → next edge: `busy`=0, `a`=`b`=0, `err_count`=0, no `done`. A following `start` completes a normal 16-cycle sweep.
- **SETTLE=0:** good datapath → `busy` high for 8 cycles, `done` in cycle 9, `pass`=1.
